instr_entry_buffer: RTL and testbench

Parametrised instruction-entry front end and instruction store for the 8-bit CPU. An operator sets switches and pulses enter to load the opcode, register ID 1, register ID 2 and immediate fields in turn. The block then packs the fields into one instruction word and writes it into a DEPTH-entry memory at an auto-incrementing address. The CPU fetch stage reads the memory through a registered read port.

---
 rtl/instr_entry_buffer.sv | 172 +++++++++++++++++
 tb/tb_instr_entry_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_entry_buffer.sv
// Operator instruction-entry FSM plus DEPTH-entry instruction store with a registered fetch port.
// Optional debug comparator on the assembled word is enabled by defining INSTR_MATCH_EN.
module instr_entry_buffer #(
  parameter int OP_W  = 4,
  parameter int REG_W = 3,
  parameter int IMM_W = 8,
  parameter int SW_W  = 8,
  parameter int DEPTH = 16,
  parameter logic [OP_W+2*REG_W+IMM_W-1:0] MATCH_WORD = '0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [SW_W-1:0]                   switches,
  input  logic                              enter,
  input  logic                              clear,
  input  logic [$clog2(DEPTH)-1:0]          rd_addr,
  output logic [OP_W+2*REG_W+IMM_W-1:0]     rd_data,
  output logic [1:0]                        stage,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              full,
  output logic                              overflow,
  output logic                              wr_done,
  output logic [OP_W+2*REG_W+IMM_W-1:0]     preview,
  output logic                              match
);

  localparam int INSTR_W = OP_W + 2*REG_W + IMM_W;
  localparam int AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH-1);

  typedef enum logic [2:0] {
    S_OPC    = 3'd0,
    S_RG1    = 3'd1,
    S_RG2    = 3'd2,
    S_IMM    = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t              state_r, state_next_s;
  logic [1:0]          stage_r;
  logic [OP_W-1:0]     op_r;
  logic [REG_W-1:0]    rg1_r, rg2_r;
  logic [IMM_W-1:0]    imm_r;
  logic [AW-1:0]       wr_ptr_r;
  logic [AW:0]         count_r;
  logic                overflow_r, wr_done_r;
  logic [INSTR_W-1:0]  rd_data_r;
  logic [INSTR_W-1:0]  mem [DEPTH];
  logic                full_s, commit_ok_s;
  logic                unused_switches;

  function automatic logic [1:0] stage_of(input state_t s);
    case (s)
      S_OPC:   stage_of = 2'd0;
      S_RG1:   stage_of = 2'd1;
      S_RG2:   stage_of = 2'd2;
      default: stage_of = 2'd3;
    endcase
  endfunction

  assign full_s          = (count_r == DEPTH_CNT);
  assign preview         = {op_r, rg1_r, rg2_r, imm_r};
  assign commit_ok_s     = (state_r == S_COMMIT) && !full_s && !clear && !reset;
  assign unused_switches = ^switches;

  // Next-state logic: clear rewinds to OPC, enter in COMMIT has no effect
  always_comb begin
    state_next_s = state_r;
    if (clear) begin
      state_next_s = S_OPC;
    end else begin
      case (state_r)
        S_OPC:    if (enter) state_next_s = S_RG1;    else state_next_s = S_OPC;
        S_RG1:    if (enter) state_next_s = S_RG2;    else state_next_s = S_RG1;
        S_RG2:    if (enter) state_next_s = S_IMM;    else state_next_s = S_RG2;
        S_IMM:    if (enter) state_next_s = S_COMMIT; else state_next_s = S_IMM;
        S_COMMIT: state_next_s = S_OPC;
        default:  state_next_s = S_OPC;
      endcase
    end
  end

  // State register with registered stage code
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_OPC;
      stage_r <= 2'd0;
    end else begin
      state_r <= state_next_s;
      stage_r <= stage_of(state_next_s);
    end
  end

  // Field capture from the low switch bits; clear holds the fields
  always_ff @(posedge clock) begin
    if (reset) begin
      op_r  <= '0;
      rg1_r <= '0;
      rg2_r <= '0;
      imm_r <= '0;
    end else if (enter && !clear) begin
      case (state_r)
        S_OPC:   op_r  <= switches[OP_W-1:0];
        S_RG1:   rg1_r <= switches[REG_W-1:0];
        S_RG2:   rg2_r <= switches[REG_W-1:0];
        S_IMM:   imm_r <= switches[IMM_W-1:0];
        default: ;
      endcase
    end
  end

  // Write bookkeeping: pointer saturates at the last entry, full blocks further commits
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      wr_done_r  <= 1'b0;
    end else begin
      wr_done_r <= commit_ok_s;
      if (commit_ok_s) begin
        count_r <= count_r + 1'b1;
        if (wr_ptr_r != LAST_PTR) wr_ptr_r <= wr_ptr_r + 1'b1;
      end else if (state_r == S_COMMIT) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Instruction memory write port; contents survive reset
  always_ff @(posedge clock) begin
    if (commit_ok_s) mem[wr_ptr_r] <= preview;
  end

  // Registered fetch port: read-before-write on a same-address collision
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_r <= '0;
    end else if (clear) begin
      rd_data_r <= rd_data_r;
    end else if (int'(rd_addr) < DEPTH) begin
      rd_data_r <= mem[rd_addr];
    end else begin
      rd_data_r <= '0;
    end
  end

  assign rd_data  = rd_data_r;
  assign stage    = stage_r;
  assign count    = count_r;
  assign full     = full_s;
  assign overflow = overflow_r;
  assign wr_done  = wr_done_r;

`ifdef INSTR_MATCH_EN
  logic match_r;

  // Debug LED: one-cycle-late comparison of the assembled word
  always_ff @(posedge clock) begin
    if (reset) match_r <= 1'b0;
    else       match_r <= (preview == MATCH_WORD);
  end

  assign match = match_r;
`else
  logic unused_match_word;
  assign unused_match_word = ^MATCH_WORD;
  assign match = 1'b0;
`endif

endmodule

// File: tb/tb_instr_entry_buffer.sv
// Self-checking bench for instr_entry_buffer: randomized entry traffic against a queue-free array model.
module tb_instr_entry_buffer;
  localparam int DEPTH = 16;
  localparam logic [17:0] MW = 18'h04000;

  logic        clock = 1'b0;
  logic        reset, enter, clear;
  logic [7:0]  switches;
  logic [3:0]  rd_addr;
  logic [17:0] rd_data, preview;
  logic [1:0]  stage;
  logic [4:0]  count;
  logic        full, overflow, wr_done, match;

  instr_entry_buffer #(.OP_W(4), .REG_W(3), .IMM_W(8), .SW_W(8), .DEPTH(DEPTH), .MATCH_WORD(MW)) dut (
    .clock(clock), .reset(reset), .switches(switches), .enter(enter), .clear(clear),
    .rd_addr(rd_addr), .rd_data(rd_data), .stage(stage), .count(count), .full(full),
    .overflow(overflow), .wr_done(wr_done), .preview(preview), .match(match)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: memory image, fill level, sticky overflow, field values
  logic [17:0] m_mem [DEPTH];
  int          m_count;
  bit          m_ovf;
  logic [3:0]  m_op;
  logic [2:0]  m_rg1, m_rg2;
  logic [7:0]  m_imm;

  function automatic logic [17:0] m_word();
    return {m_op, m_rg1, m_rg2, m_imm};
  endfunction

  function automatic bit model_commit();
    if (m_count < DEPTH) begin
      m_mem[m_count] = m_word();
      m_count++;
      return 1'b1;
    end
    m_ovf = 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enter_field(input logic [7:0] v);
    switches = v;
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic enter_instr(input logic [3:0] op, input logic [2:0] r1, input logic [2:0] r2, input logic [7:0] imm);
    logic [7:0] u;
    u = 8'($urandom); enter_field({u[7:4], op});     m_op  = op;
    u = 8'($urandom); enter_field({u[7:3], r1});     m_rg1 = r1;
    u = 8'($urandom); enter_field({u[7:3], r2});     m_rg2 = r2;
    enter_field(imm);                                m_imm = imm;
  endtask

  task automatic test_reset();
    reset = 1'b1; enter = 1'b0; clear = 1'b0; switches = 8'h00; rd_addr = 4'd0;
    tick(); tick();
    reset = 1'b0;
    m_count = 0; m_ovf = 1'b0; m_op = 4'h0; m_rg1 = 3'h0; m_rg2 = 3'h0; m_imm = 8'h00;
    n_tests++; if (stage !== 2'd0)     begin n_fail++; $display("FAIL reset_stage: got %0d want 0", stage); end
    n_tests++; if (count !== 5'd0)     begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (full !== 1'b0)      begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_tests++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_tests++; if (wr_done !== 1'b0)   begin n_fail++; $display("FAIL reset_wr_done: got %b want 0", wr_done); end
    n_tests++; if (rd_data !== 18'h0)  begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    n_tests++; if (preview !== 18'h0)  begin n_fail++; $display("FAIL reset_preview: got %h want 0", preview); end
    n_tests++; if (match !== 1'b0)     begin n_fail++; $display("FAIL reset_match: got %b want 0", match); end
  endtask

  task automatic test_basic();
    bit ok;
    enter_field(8'h01); m_op = 4'h1;
    n_tests++; if (stage !== 2'd1)       begin n_fail++; $display("FAIL basic_stage_rg1: got %0d want 1", stage); end
    n_tests++; if (preview !== m_word()) begin n_fail++; $display("FAIL basic_preview_op: got %h want %h", preview, m_word()); end
    enter_field(8'h02); m_rg1 = 3'h2;
    enter_field(8'h03); m_rg2 = 3'h3;
    n_tests++; if (preview !== m_word()) begin n_fail++; $display("FAIL basic_preview_rg2: got %h want %h", preview, m_word()); end
    enter_field(8'hA5); m_imm = 8'hA5;
    n_tests++; if (preview !== 18'h053A5) begin n_fail++; $display("FAIL basic_preview_imm: got %h want 053a5", preview); end
    n_tests++; if (stage !== 2'd3)        begin n_fail++; $display("FAIL basic_stage_commit: got %0d want 3", stage); end
    switches = 8'h0F; enter = 1'b1;
    ok = model_commit();
    tick();
    enter = 1'b0;
    n_tests++; if (wr_done !== ok)         begin n_fail++; $display("FAIL basic_wr_done: got %b want %b", wr_done, ok); end
    n_tests++; if (count !== 5'(m_count))  begin n_fail++; $display("FAIL basic_count: got %0d want %0d", count, m_count); end
    n_tests++; if (stage !== 2'd0)         begin n_fail++; $display("FAIL basic_commit_enter_ignored: got stage %0d want 0", stage); end
    n_tests++; if (preview !== 18'h053A5)  begin n_fail++; $display("FAIL basic_preview_hold: got %h want 053a5", preview); end
    tick();
    n_tests++; if (wr_done !== 1'b0)       begin n_fail++; $display("FAIL basic_wr_done_pulse: got %b want 0", wr_done); end
    rd_addr = 4'd0; tick();
    n_tests++; if (rd_data !== 18'h053A5)  begin n_fail++; $display("FAIL basic_mem0: got %h want 053a5", rd_data); end
  endtask

  task automatic test_upper_bits();
    bit ok;
    enter_field(8'hFF); m_op = 4'hF;
    n_tests++; if (preview[17:14] !== 4'hF) begin n_fail++; $display("FAIL upper_op: got %h want f", preview[17:14]); end
    n_tests++; if (preview !== m_word())    begin n_fail++; $display("FAIL upper_preview: got %h want %h", preview, m_word()); end
    enter_field(8'hFF); m_rg1 = 3'h7;
    enter_field(8'hFA); m_rg2 = 3'h2;
    enter_field(8'h3C); m_imm = 8'h3C;
    ok = model_commit();
    tick();
    n_tests++; if (wr_done !== ok)        begin n_fail++; $display("FAIL upper_wr_done: got %b want %b", wr_done, ok); end
    n_tests++; if (count !== 5'(m_count)) begin n_fail++; $display("FAIL upper_count: got %0d want %0d", count, m_count); end
  endtask

  task automatic test_fill_overflow();
    bit ok;
    while (m_count < DEPTH) begin
      n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_full_early: got %b at count %0d", full, m_count); end
      enter_instr(4'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
      ok = model_commit();
      tick();
      n_tests++; if (wr_done !== ok)        begin n_fail++; $display("FAIL fill_wr_done: got %b want %b", wr_done, ok); end
      n_tests++; if (count !== 5'(m_count)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", count, m_count); end
    end
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
    enter_instr(4'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
    ok = model_commit();
    tick();
    n_tests++; if (wr_done !== ok)          begin n_fail++; $display("FAIL ovf_wr_done: got %b want %b", wr_done, ok); end
    n_tests++; if (count !== 5'(m_count))   begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", count, m_count); end
    n_tests++; if (overflow !== m_ovf)      begin n_fail++; $display("FAIL ovf_flag: got %b want %b", overflow, m_ovf); end
    n_tests++; if (full !== 1'b1)           begin n_fail++; $display("FAIL ovf_full: got %b want 1", full); end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 4'(a);
      tick();
      n_tests++; if (rd_data !== m_mem[a]) begin n_fail++; $display("FAIL readback[%0d]: got %h want %h", a, rd_data, m_mem[a]); end
    end
  endtask

  task automatic test_collision();
    bit ok;
    logic [17:0] old3;
    clear = 1'b1; tick(); clear = 1'b0;
    m_count = 0; m_ovf = 1'b0;
    n_tests++; if (count !== 5'd0)    begin n_fail++; $display("FAIL clear_count: got %0d want 0", count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clear_overflow: got %b want 0", overflow); end
    n_tests++; if (full !== 1'b0)     begin n_fail++; $display("FAIL clear_full: got %b want 0", full); end
    for (int i = 0; i < 3; i++) begin
      enter_instr(4'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
      ok = model_commit();
      tick();
    end
    old3 = m_mem[3];
    enter_instr(4'($urandom), 3'($urandom), 3'($urandom), ~old3[7:0]);
    rd_addr = 4'd3;
    ok = model_commit();
    tick();
    n_tests++; if (rd_data !== old3)     begin n_fail++; $display("FAIL collide_old: got %h want %h", rd_data, old3); end
    n_tests++; if (wr_done !== ok)       begin n_fail++; $display("FAIL collide_wr_done: got %b want %b", wr_done, ok); end
    tick();
    n_tests++; if (rd_data !== m_mem[3]) begin n_fail++; $display("FAIL collide_new: got %h want %h", rd_data, m_mem[3]); end
  endtask

  task automatic test_clear_mid();
    bit ok;
    logic [17:0] held;
    enter_instr(4'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
    ok = model_commit();
    tick();
    n_tests++; if (count !== 5'd5) begin n_fail++; $display("FAIL clrmid_count5: got %0d want 5", count); end
    enter_field(8'h09); m_op = 4'h9;
    enter_field(8'h04); m_rg1 = 3'h4;
    enter_field(8'h06); m_rg2 = 3'h6;
    held = m_word();
    clear = 1'b1; tick(); clear = 1'b0;
    m_count = 0; m_ovf = 1'b0;
    n_tests++; if (stage !== 2'd0)     begin n_fail++; $display("FAIL clrmid_stage: got %0d want 0", stage); end
    n_tests++; if (count !== 5'd0)     begin n_fail++; $display("FAIL clrmid_count: got %0d want 0", count); end
    n_tests++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL clrmid_overflow: got %b want 0", overflow); end
    n_tests++; if (preview !== held)   begin n_fail++; $display("FAIL clrmid_fields_held: got %h want %h", preview, held); end
    // clear landing on the commit cycle must cancel the write
    enter_instr(4'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
    clear = 1'b1; tick(); clear = 1'b0;
    n_tests++; if (wr_done !== 1'b0)   begin n_fail++; $display("FAIL clrcommit_wr_done: got %b want 0", wr_done); end
    n_tests++; if (count !== 5'd0)     begin n_fail++; $display("FAIL clrcommit_count: got %0d want 0", count); end
    rd_addr = 4'd0; tick();
    n_tests++; if (rd_data !== m_mem[0]) begin n_fail++; $display("FAIL clrcommit_mem0: got %h want %h", rd_data, m_mem[0]); end
    enter_instr(4'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
    ok = model_commit();
    tick();
    n_tests++; if (wr_done !== ok)     begin n_fail++; $display("FAIL clrmid_next_wr_done: got %b want %b", wr_done, ok); end
    tick();
    n_tests++; if (rd_data !== m_mem[0]) begin n_fail++; $display("FAIL clrmid_next_mem0: got %h want %h", rd_data, m_mem[0]); end
  endtask

  task automatic test_match();
    bit ok;
    logic exp_match;
`ifdef INSTR_MATCH_EN
    exp_match = 1'b1;
`else
    exp_match = 1'b0;
`endif
    enter_instr(4'h2, 3'h1, 3'h1, 8'h5A);
    ok = model_commit();
    tick();
    enter_field(8'h01); m_op = 4'h1;
    enter_field(8'h00); m_rg1 = 3'h0;
    enter_field(8'h00); m_rg2 = 3'h0;
    enter_field(8'h00); m_imm = 8'h00;
    n_tests++; if (preview !== MW)   begin n_fail++; $display("FAIL match_preview: got %h want %h", preview, MW); end
    n_tests++; if (match !== 1'b0)   begin n_fail++; $display("FAIL match_lag: got %b want 0", match); end
    ok = model_commit();
    tick();
    n_tests++; if (match !== exp_match) begin n_fail++; $display("FAIL match_after_imm: got %b want %b", match, exp_match); end
  endtask

  task automatic test_reset_mid();
    enter_field(8'h07);
    enter_field(8'h05);
    reset = 1'b1; tick(); reset = 1'b0;
    m_count = 0; m_ovf = 1'b0; m_op = 4'h0; m_rg1 = 3'h0; m_rg2 = 3'h0; m_imm = 8'h00;
    n_tests++; if (stage !== 2'd0)    begin n_fail++; $display("FAIL rstmid_stage: got %0d want 0", stage); end
    n_tests++; if (preview !== 18'h0) begin n_fail++; $display("FAIL rstmid_preview: got %h want 0", preview); end
    n_tests++; if (count !== 5'd0)    begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", count); end
    n_tests++; if (rd_data !== 18'h0) begin n_fail++; $display("FAIL rstmid_rd_data: got %h want 0", rd_data); end
    n_tests++; if (match !== 1'b0)    begin n_fail++; $display("FAIL rstmid_match: got %b want 0", match); end
    rd_addr = 4'd0; tick();
    n_tests++; if (rd_data !== m_mem[0]) begin n_fail++; $display("FAIL rstmid_mem_kept: got %h want %h", rd_data, m_mem[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_upper_bits();
    test_fill_overflow();
    test_collision();
    test_clear_mid();
    test_match();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
